// File: rtl/rr_arb_mux.sv
// Round-robin arbiter that muxes N_IN valid/ready channels into one registered output stage.
// Supports grant locking so a channel can keep winning while it stays valid.
module rr_arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]         in_ready,
    input  logic                    lock,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    localparam logic [SEL_W:0]   N_LIM   = (SEL_W + 1)'(N_IN);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0]  r_ptr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    logic [2*N_IN-1:0] w_dbl;
    logic [N_IN-1:0]   w_rot;
    logic [SEL_W-1:0]  w_off;
    logic [SEL_W:0]    w_sum;
    logic [SEL_W-1:0]  w_winner;
    logic [WIDTH-1:0]  w_win_data;
    logic              w_any;
    logic              w_load;
    logic [N_IN-1:0]   w_ready;
    logic [SEL_W-1:0]  w_ptr_next;

    // Rotate requests so bit 0 is the channel at the pointer; first set bit is the offset.
    always_comb begin
        w_dbl = {in_valid, in_valid};
        w_rot = N_IN'(w_dbl >> r_ptr);
        w_off = '0;
        for (int k = int'(N_IN) - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
        w_sum = (SEL_W + 1)'(r_ptr) + (SEL_W + 1)'(w_off);
        if (w_sum >= N_LIM) begin
            w_sum = w_sum - N_LIM;
        end
        w_winner = w_sum[SEL_W-1:0];
    end

    assign w_any  = |in_valid;
    assign w_load = !rst && (!r_out_valid || out_ready) && w_any;

    always_comb begin
        w_win_data = '0;
        w_ready    = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (w_winner == SEL_W'(i)) begin
                w_win_data = in_data[i*WIDTH +: WIDTH];
                w_ready[i] = w_load;
            end
        end
    end

    always_comb begin
        w_ptr_next = r_ptr;
        if (w_load) begin
            if (lock) begin
                w_ptr_next = w_winner;
            end else if (w_winner == LAST_CH) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = w_winner + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else begin
            r_ptr <= w_ptr_next;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_data;
                r_out_sel   <= w_winner;
            end else if (out_ready) begin
                // Drain: data and index keep their last values.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: reference model plus scoreboard of accepted words,
// directed scenarios followed by a random phase.
module tb_rr_arb_mux;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_IN  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_ready;
    logic                  lock;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_sel;
    logic                  out_ready;

    rr_arb_mux #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .lock      (lock),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          m_ptr   = 0;
    logic        m_ov    = 1'b0;
    logic [31:0] m_od    = '0;
    logic [1:0]  m_os    = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_win(input int ptr, input logic [3:0] v);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One cycle: check at negedge+1, model update at posedge, return at next negedge.
    task automatic step();
        int         w;
        logic       ld;
        logic [3:0] er;
        logic       ordy;
        logic       rs;
        logic       lk;
        logic [3:0] iv;
        logic [127:0] id;
        #1;
        ld = !rst && (!m_ov || out_ready) && (|in_valid);
        w  = m_win(m_ptr, in_valid);
        er = ld ? 4'(1 << w) : 4'b0;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (!rst) begin
            if (m_ov) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    chk("out_data", 64'(out_data), 64'(sb[0].data));
                    chk("out_sel", 64'(out_sel), 64'(sb[0].sel));
                    if (out_ready) sb.delete(0);
                end
            end else begin
                chk("idle_data", 64'(out_data), 64'(m_od));
                chk("idle_sel", 64'(out_sel), 64'(m_os));
            end
        end
        ordy = out_ready; rs = rst; lk = lock; iv = in_valid; id = in_data;
        @(posedge clk);
        if (rs) begin
            m_ov = 1'b0; m_od = '0; m_os = '0; m_ptr = 0;
            sb.delete();
        end else if (ld) begin
            m_ov = 1'b1;
            m_od = id[w*32 +: 32];
            m_os = 2'(w);
            sb.push_back('{sel: 2'(w), data: id[w*32 +: 32]});
            m_ptr = lk ? w : (w + 1) % 4;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic seq_data();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b1111; lock = 1'b0; out_ready = 1'b1;
        seq_data();
        @(posedge clk);
        @(negedge clk);
        // Reset held with all requests: in_ready must be zero.
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sel", 64'(out_sel), 64'd0);

        // Rotation
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rot_sel", 64'(out_sel), 64'(k % 4));
            chk("rot_data", 64'(out_data), 64'(32'hA0 + 32'(k % 4)));
        end

        // Stall holding A1
        step();
        chk("stall_load", 64'(out_data), 64'h0A1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_data", 64'(out_data), 64'h0A1);
            chk("stall_sel", 64'(out_sel), 64'd1);
        end
        out_ready = 1'b1;
        step();
        chk("unstall_sel", 64'(out_sel), 64'd2);

        // Lock on channel 2
        lock = 1'b1; in_valid = 4'b0100;
        step();
        chk("lock_sel0", 64'(out_sel), 64'd2);
        in_valid = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("lock_sel", 64'(out_sel), 64'd2);
        end
        lock = 1'b0; in_valid = 4'b1001;
        step();
        chk("unlock_to3", 64'(out_sel), 64'd3);
        lock = 1'b1; in_valid = 4'b0100;
        step();
        lock = 1'b0; in_valid = 4'b0001;
        step();
        chk("unlock_to0", 64'(out_sel), 64'd0);

        // Sparse then drain
        in_valid = 4'b1000;
        step();
        chk("sparse_sel", 64'(out_sel), 64'd3);
        in_valid = 4'b0000;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_sel", 64'(out_sel), 64'd3);
        chk("drain_data", 64'(out_data), 64'h0A3);
        in_valid = 4'b0010;
        step();
        chk("wrap_sel", 64'(out_sel), 64'd1);

        // Reset while stalled
        in_valid = 4'b1111; out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("midrst_sel", 64'(out_sel), 64'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(99) < 2);
            in_valid  = 4'($urandom);
            lock      = ($urandom_range(99) < 25);
            out_ready = ($urandom_range(99) < 70);
            for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
            step();
        end

        rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1; lock = 1'b0;
        step();
        step();
        chk("sb_left", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of every input channel and of the output, in bits.
REQ-002 Parameter N_IN, default 4: number of input channels; legal range 1..16.
REQ-003 Derived constant SEL_W = max(1, clog2(N_IN)): width of the channel index.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, N_IN: bit i set means channel i presents a word.
REQ-007 Port in_data, input, N_IN*WIDTH: channel i word at bits [i*WIDTH +: WIDTH].
REQ-008 Port in_ready, output, N_IN: bit i set means channel i's word is accepted this cycle.
REQ-009 Port lock, input, 1: keeps the current grant on the same channel for the next arbitration.
REQ-010 Port out_valid, output, 1: output register holds a word.
REQ-011 Port out_data, output, WIDTH: held word.
REQ-012 Port out_sel, output, SEL_W: index of the channel that supplied out_data.
REQ-013 Port out_ready, input, 1: consumer accepts the held word this cycle.

Function
REQ-014 Load condition: load = (!out_valid || out_ready) && (|in_valid).
REQ-015 Winner: the first set bit of in_valid, scanning ptr, ptr+1, ... N_IN-1, 0, ... ptr-1 (mod N_IN).
REQ-016 in_ready: one-hot at the winner when load is 1, all-zero otherwise; combinational from the current state and inputs.
REQ-017 On a load edge: out_valid <= 1, out_data <= the winner's word, out_sel <= the winner's index.
REQ-018 Latency: exactly 1 cycle from the in_valid/in_ready handshake to out_valid.
REQ-019 Throughput: one word per cycle while out_ready stays 1.
REQ-020 Drain: when out_ready=1 and no input is valid, out_valid <= 0, and out_data/out_sel keep their last values.
REQ-021 Stall: while out_valid=1 and out_ready=0, out_valid, out_data and out_sel stay stable and in_ready is all-zero.
REQ-022 Pointer update on load, lock=0: ptr <= (winner+1) mod N_IN.
REQ-023 Pointer update on load, lock=1: ptr <= winner, so that channel wins again if it stays valid.
REQ-024 If a locked channel drops in_valid, the scan from ptr skips it; no extra idle cycle is inserted.
REQ-025 ptr does not change in cycles without a load.
REQ-026 Fairness: with lock=0 and all channels continuously valid, grants rotate 0,1,...,N_IN-1,0,...
REQ-027 N_IN=1: ptr is constant 0, out_sel is constant 0, and the block behaves as a 1-deep registered valid/ready stage.
REQ-028 The block does not modify data: out_data equals the accepted in_data word bit-for-bit.
REQ-029 in_valid bits are not required to stay asserted without a grant; a withdrawn request is not an error.

Reset
REQ-030 While rst=1 at the clock edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-031 While rst=1, in_ready is forced all-zero, regardless of the other inputs.
REQ-032 Reset while a word is held discards that word; it never appears at the output after reset.
REQ-033 First cycle after reset release: arbitration starts at channel 0.

Verification
REQ-034 Reset: rst=1 with in_valid=4'b1111 -> in_ready=0; next cycle out_valid=0, out_data=0, out_sel=0.
REQ-035 Rotation: N_IN=4, all valid, in_data i = 32'hA0+i, out_ready=1, lock=0 -> out_sel 0,1,2,3,0 and out_data 32'hA0,A1,A2,A3,A0 on consecutive cycles.
REQ-036 Stall: out_valid=1 holding 32'hA1, out_ready=0 for 3 cycles -> out_data stays 32'hA1, in_ready=0 throughout; out_ready=1 -> next word loads the same cycle.
REQ-037 Lock: lock=1, channel 2 valid with 3 words, channel 0 also valid -> out_sel=2,2,2; channel 2 drops valid -> next grant goes to channel 3 if valid, else channel 0.
REQ-038 Sparse/drain: only channel 3 valid for 1 cycle, then all idle, out_ready=1 -> one word with out_sel=3, then out_valid=0; next request from channel 1 wins (ptr=0 after the wrap).
REQ-039 Mid-reset: rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, and the next grant with all channels valid goes to channel 0.
